sipo_deser: RTL and testbench

Serial-in parallel-out deserializer: the receiving end of the team's `piso` serial link. It collects WIDTH serial bits, framed by a start strobe and qualified per bit, into a shift register. It then presents each completed word on a double-buffered parallel output with a valid/ready handshake. It sits between the serial line (driven by `piso.so`) and the parallel consumer logic.

---
 rtl/sipo_pkg.sv | 11 +
 rtl/sipo_deser_if.sv | 35 +++
 rtl/sipo_shreg.sv | 57 +++++
 rtl/sipo_deser.sv | 93 +++++++++
 tb/tb_sipo_deser.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and defaults for the sipo_deser deserializer
package sipo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    localparam int SIPO_DEF_WIDTH = 8;

endpackage

// File: rtl/sipo_deser_if.sv
// rtl/sipo_deser_if.sv - serial input and parallel handshake bundle for sipo_deser
// Signals:
//   si, si_en, start    serial bit, bit qualifier, frame start
//   po, po_valid        parallel word and its valid flag
//   po_ready            consumer accepts po
//   busy, overrun       frame in progress, sticky dropped-word flag
//   ovr_clr             clears overrun
// The slave modport is the deserializer side; master is the driving side.
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH
);

    logic             si;
    logic             si_en;
    logic             start;
    logic [WIDTH-1:0] po;
    logic             po_valid;
    logic             po_ready;
    logic             busy;
    logic             overrun;
    logic             ovr_clr;

    modport slave (
        input  si, si_en, start, po_ready, ovr_clr,
        output po, po_valid, busy, overrun
    );

    modport master (
        output si, si_en, start, po_ready, ovr_clr,
        input  po, po_valid, busy, overrun
    );

endinterface

// File: rtl/sipo_shreg.sv
// rtl/sipo_shreg.sv - shift register and bit counter for sipo_deser
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         take si as bit 0 of a new word, counter restarts at 1
//   shift        append si to the current word
//   si           serial bit
//   word         assembled word including the bit sampled this cycle
//   done         the bit sampled this cycle completes the word
module sipo_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             si,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;

    // word is the next register value so the holding register can capture
    // the completed word on the same edge that samples its last bit.
    always_comb begin
        sh_next = sh;
        if (load) begin
            if (MSB_FIRST) sh_next = {{(WIDTH-1){1'b0}}, si};
            else           sh_next = {si, {(WIDTH-1){1'b0}}};
        end else if (shift) begin
            if (MSB_FIRST) sh_next = {sh[WIDTH-2:0], si};
            else           sh_next = {si, sh[WIDTH-1:1]};
        end
    end

    assign word = sh_next;
    assign done = shift && !load && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= sh_next;
            cnt <= CW'(1);
        end else if (shift) begin
            sh  <= sh_next;
            cnt <= done ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with buffered valid/ready output
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   bus          sipo_deser_if slave: si/si_en/start in, po/po_valid/po_ready
//                handshake, busy and sticky overrun with ovr_clr
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    sipo_deser_if.slave  bus
);

    sipo_state_t      state;
    sipo_state_t      state_next;
    logic             load;
    logic             shift;
    logic             done;
    logic [WIDTH-1:0] word;

    logic [WIDTH-1:0] po_q;
    logic             po_valid_q;
    logic             busy_q;
    logic             overrun_q;

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .si    (bus.si),
        .word  (word),
        .done  (done)
    );

    // busy is registered off the next state so it tracks SHIFT without a
    // combinational path, and stays high when completion meets a new start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == SHIFT);
        end
    end

    always_comb begin
        state_next = state;
        if (load)      state_next = SHIFT;
        else if (done) state_next = IDLE;
    end

    // A start strobe restarts the frame from either state; bits outside a
    // frame are ignored.
    always_comb begin
        load  = bus.si_en && bus.start;
        shift = bus.si_en && !bus.start && (state == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (done) begin
                if (!po_valid_q || bus.po_ready) begin
                    po_q       <= word;
                    po_valid_q <= 1'b1;
                end
            end else if (po_valid_q && bus.po_ready) begin
                po_valid_q <= 1'b0;
            end

            // a drop in the same cycle as a clear leaves the flag set
            if (done && po_valid_q && !bus.po_ready) overrun_q <= 1'b1;
            else if (bus.ovr_clr)                    overrun_q <= 1'b0;
        end
    end

    assign bus.po       = po_q;
    assign bus.po_valid = po_valid_q;
    assign bus.busy     = busy_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed self-checking bench for sipo_deser
module tb_sipo_deser;
    import sipo_pkg::*;

    localparam int W = SIPO_DEF_WIDTH;

    logic clk = 1'b0;
    logic reset;

    sipo_deser_if #(.WIDTH(W)) bus_m ();
    sipo_deser_if #(.WIDTH(W)) bus_l ();

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       si;
        logic       si_en;
        logic       start;
        logic       ready;
        logic [7:0] exp_po;
        logic       exp_valid;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [10];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_m();
        bus_m.si = 1'b0; bus_m.si_en = 1'b0; bus_m.start = 1'b0;
        bus_m.po_ready = 1'b0; bus_m.ovr_clr = 1'b0;
    endtask

    task automatic idle_l();
        bus_l.si = 1'b0; bus_l.si_en = 1'b0; bus_l.start = 1'b0;
        bus_l.po_ready = 1'b0; bus_l.ovr_clr = 1'b0;
    endtask

    // MSB-first frame on the MSB DUT, back to back, then inputs go idle
    task automatic send_m(input logic [7:0] w, input logic ready_mid,
                          input logic ready_last, input logic clr);
        for (int i = 0; i < 8; i++) begin
            bus_m.si       = w[7-i];
            bus_m.si_en    = 1'b1;
            bus_m.start    = (i == 0);
            bus_m.po_ready = (i == 7) ? ready_last : ready_mid;
            bus_m.ovr_clr  = clr;
            step();
        end
        idle_m();
    endtask

    initial begin
        logic [7:0] pat;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};

        idle_m();
        idle_l();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        check("rst_po",       bus_m.po,       8'h00);
        check("rst_valid",    bus_m.po_valid, 1'b0);
        check("rst_busy",     bus_m.busy,     1'b0);
        check("rst_overrun",  bus_m.overrun,  1'b0);
        check("rst_l_valid",  bus_l.po_valid, 1'b0);

        // LSB-first with a gap cycle after every bit
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            bus_l.si    = pat[i];
            bus_l.si_en = 1'b1;
            bus_l.start = (i == 0);
            step();
            check("lsb_busy",  bus_l.busy,     (i == 7) ? 1'b0 : 1'b1);
            check("lsb_valid", bus_l.po_valid, (i == 7) ? 1'b1 : 1'b0);
            bus_l.si    = 1'b1;
            bus_l.si_en = 1'b0;
            bus_l.start = 1'b0;
            step();
            if (i < 7) check("lsb_gap_valid", bus_l.po_valid, 1'b0);
        end
        check("lsb_po",     bus_l.po,    8'hA5);
        check("lsb_po0",    bus_l.po[0], 1'b1);
        bus_l.po_ready = 1'b1;
        step();
        check("lsb_accept", bus_l.po_valid, 1'b0);
        bus_l.po_ready = 1'b0;
        pat = 8'h01;
        for (int i = 0; i < 8; i++) begin
            bus_l.si    = pat[i];
            bus_l.si_en = 1'b1;
            bus_l.start = (i == 0);
            step();
        end
        idle_l();
        check("lsb_po_01", bus_l.po, 8'h01);

        // MSB-first basic frame, table driven
        for (int i = 0; i < 10; i++) begin
            bus_m.si       = tbl[i].si;
            bus_m.si_en    = tbl[i].si_en;
            bus_m.start    = tbl[i].start;
            bus_m.po_ready = tbl[i].ready;
            step();
            check($sformatf("tbl%0d_po", i),    bus_m.po,       tbl[i].exp_po);
            check($sformatf("tbl%0d_valid", i), bus_m.po_valid, tbl[i].exp_valid);
            check($sformatf("tbl%0d_busy", i),  bus_m.busy,     tbl[i].exp_busy);
        end
        idle_m();

        // backpressure and overrun; clear held during the dropping edge
        send_m(8'h3C, 1'b0, 1'b0, 1'b0);
        check("bp_po1",      bus_m.po,       8'h3C);
        check("bp_valid1",   bus_m.po_valid, 1'b1);
        check("bp_ovr1",     bus_m.overrun,  1'b0);
        send_m(8'hC3, 1'b0, 1'b0, 1'b1);
        check("bp_po2",      bus_m.po,       8'h3C);
        check("bp_valid2",   bus_m.po_valid, 1'b1);
        check("bp_ovr_wins", bus_m.overrun,  1'b1);
        bus_m.ovr_clr = 1'b1;
        step();
        bus_m.ovr_clr = 1'b0;
        check("bp_ovr_clr",  bus_m.overrun,  1'b0);
        check("bp_valid3",   bus_m.po_valid, 1'b1);
        bus_m.po_ready = 1'b1;
        step();
        bus_m.po_ready = 1'b0;
        check("bp_accept",   bus_m.po_valid, 1'b0);
        check("bp_po_keep",  bus_m.po,       8'h3C);

        // completion coincides with accept of the held word
        send_m(8'h11, 1'b0, 1'b0, 1'b0);
        check("sim_po1",   bus_m.po,       8'h11);
        send_m(8'h22, 1'b0, 1'b1, 1'b0);
        check("sim_po2",   bus_m.po,       8'h22);
        check("sim_valid", bus_m.po_valid, 1'b1);
        check("sim_ovr",   bus_m.overrun,  1'b0);
        bus_m.po_ready = 1'b1;
        step();
        bus_m.po_ready = 1'b0;
        check("sim_accept", bus_m.po_valid, 1'b0);

        // restart after 5 bits of a partial frame
        for (int i = 0; i < 5; i++) begin
            bus_m.si    = 1'b1;
            bus_m.si_en = 1'b1;
            bus_m.start = (i == 0);
            step();
        end
        idle_m();
        check("rs_busy",  bus_m.busy,     1'b1);
        check("rs_valid", bus_m.po_valid, 1'b0);
        send_m(8'hF0, 1'b0, 1'b0, 1'b0);
        check("rs_po",    bus_m.po,       8'hF0);
        check("rs_valid2", bus_m.po_valid, 1'b1);
        check("rs_busy2", bus_m.busy,     1'b0);

        // reset mid-frame after building up overrun and a held word
        send_m(8'h55, 1'b0, 1'b0, 1'b0);
        check("rm_pre_ovr", bus_m.overrun, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus_m.si    = 1'b1;
            bus_m.si_en = 1'b1;
            bus_m.start = (i == 0);
            step();
        end
        idle_m();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_busy",  bus_m.busy,     1'b0);
        check("rm_po",    bus_m.po,       8'h00);
        check("rm_valid", bus_m.po_valid, 1'b0);
        check("rm_ovr",   bus_m.overrun,  1'b0);
        for (int i = 0; i < 8; i++) begin
            bus_m.si    = 1'b1;
            bus_m.si_en = 1'b1;
            step();
        end
        idle_m();
        check("rm_nostart_busy",  bus_m.busy,     1'b0);
        check("rm_nostart_valid", bus_m.po_valid, 1'b0);
        send_m(8'h81, 1'b0, 1'b0, 1'b0);
        check("rm_after_po",    bus_m.po,       8'h81);
        check("rm_after_valid", bus_m.po_valid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
